// File: rtl/gtob_seq_conv.sv
// Bit-serial Gray-to-binary decoder, MSB first, with valid/ready on both sides.
// Optional step check (successive accepted codes one bit apart) enabled by GTOB_STEP_CHECK_EN.
module gtob_seq_conv #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             step_err
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        bin_d       = bin_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shadow_d = gray;
                    bin_d    = {gray[WIDTH-1], {(WIDTH-1){1'b0}}};
                    idx_d    = IW'(WIDTH - 2);
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                // Each bit folds the already-decoded bit above it with its own Gray bit.
                bin_d[idx_q] = bin_q[idx_q + 1'b1] ^ shadow_q[idx_q];
                if (idx_q == '0) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            bin_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            bin_q       <= bin_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign bin       = bin_q;

`ifdef GTOB_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             first_q, first_d;
    logic             pend_q, pend_d;
    logic             step_err_q, step_err_d;
    logic             accept;
    logic             last_step;

    always_comb begin
        accept     = (state_q == S_IDLE) && in_valid;
        last_step  = (state_q == S_CONV) && (idx_q == '0);
        prev_d     = prev_q;
        first_d    = first_q;
        pend_d     = pend_q;
        step_err_d = step_err_q;
        // The verdict is taken at accept but only published when the result appears.
        if (accept) begin
            pend_d  = !first_q && ($countones(gray ^ prev_q) != 1);
            prev_d  = gray;
            first_d = 1'b0;
        end
        if (last_step) begin
            step_err_d = pend_q;
        end else if ((state_q == S_DONE) && out_ready) begin
            step_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            first_q    <= 1'b1;
            pend_q     <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
            step_err_q <= step_err_d;
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gtob_seq_conv.sv
// Self-checking bench for gtob_seq_conv: directed cases, exhaustive sweep, backpressure,
// mid-conversion reset and randomized words against a prefix-XOR reference model.
module tb_gtob_seq_conv;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bin;
    logic         busy;
    logic         step_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc  = 0;
    int last_acc = 0;

    logic [W-1:0] m_prev  = '0;
    bit           m_first = 1'b1;
    logic         last_exp_err = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gtob_seq_conv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray      (gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .busy      (busy),
        .step_err  (step_err)
    );

    // bin[i] is the parity of all Gray bits at or above position i.
    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    function automatic logic ref_err(input logic [W-1:0] g);
        logic d;
        d = !m_first && ($countones(g ^ m_prev) != 1);
`ifdef GTOB_STEP_CHECK_EN
        return d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] g, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        gray     = g;
        in_valid = 1'b1;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        gray     = W'($urandom);
        last_exp_err = ref_err(g);
        m_prev  = g;
        m_first = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, W - 1);
        chk({tag, "_bin"}, bin, ref_bin(g));
        chk({tag, "_step_err"}, step_err, last_exp_err);
        $display("txn %s gray=%b bin=%b step_err=%b latency=%0d", tag, g, bin, step_err, n);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        chk({tag, "_hs_out_valid"}, out_valid, 0);
        chk({tag, "_hs_busy"}, busy, 0);
        chk({tag, "_hs_step_err"}, step_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] g;
        int dly;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; gray = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bin", bin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step_err", step_err, 0);

        // Step-check sequence right after reset: expected flags 0,0,1,1 when enabled.
        send(4'b0001, "step0"); handshake("step0"); out_ready = 1'b0;
        send(4'b0011, "step1"); handshake("step1"); out_ready = 1'b0;
        send(4'b0000, "step2");
`ifdef GTOB_STEP_CHECK_EN
        chk("step2_const", step_err, 1);
`else
        chk("step2_const", step_err, 0);
`endif
        handshake("step2"); out_ready = 1'b0;
        send(4'b0000, "step3"); handshake("step3"); out_ready = 1'b0;

        send(4'b0110, "d0110"); chk("d0110_const", bin, 4'b0100); handshake("d0110"); out_ready = 1'b0;
        send(4'b1000, "d1000"); chk("d1000_const", bin, 4'b1111); handshake("d1000"); out_ready = 1'b0;
        send(4'b0000, "d0000"); chk("d0000_const", bin, 4'b0000); handshake("d0000"); out_ready = 1'b0;

        // Exhaustive sweep with out_ready held high (also asserted before out_valid).
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(W'(k), "sweep");
            chk("sweep_inverse", bin ^ (bin >> 1), k);
            if (k > 0) chk("sweep_period", acc_cyc - last_acc, W + 1);
            last_acc = acc_cyc;
        end
        handshake("sweep");
        out_ready = 1'b0;

        // Backpressure with stray in_valid pulses.
        send(4'b0111, "bp");
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            gray     = W'($urandom);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_bin", bin, 4'b0101);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_step_err", step_err, last_exp_err);
        end
        in_valid = 1'b1;
        gray     = 4'b1010;
        handshake("bp");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("bp_no_accept", busy, 0);

        // Reset during the second CONV cycle.
        gray = 4'b1011; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_first = 1'b1;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_bin", bin, 0);
        chk("mid_busy", busy, 0);
        chk("mid_step_err", step_err, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mid_quiet", out_valid, 0);
        end
        send(4'b1011, "post_rst"); handshake("post_rst"); out_ready = 1'b0;

        // Randomized words with random backpressure.
        for (int k = 0; k < 20; k++) begin
            g = W'($urandom);
            send(g, "rand");
            dly = $urandom_range(0, 3);
            for (int j = 0; j < dly; j++) begin
                tick();
                chk("rand_hold_valid", out_valid, 1);
                chk("rand_hold_bin", bin, ref_bin(g));
            end
            handshake("rand");
            out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
